// File: rtl/wisc_pkg.sv
// Shared ISA definitions for the EX stage: ALU opcodes, branch condition codes
// and the packed condition-flag record.
package wisc_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_NOR = 3'b011,
      OP_SLL = 3'b100,
      OP_SRL = 3'b101,
      OP_LHB = 3'b110,
      OP_SRA = 3'b111
   } alu_op_e;

   typedef enum logic [2:0] {
      BR_NEQ    = 3'b000,
      BR_EQ     = 3'b001,
      BR_GT     = 3'b010,
      BR_LT     = 3'b011,
      BR_GTE    = 3'b100,
      BR_LTE    = 3'b101,
      BR_OVFL   = 3'b110,
      BR_UNCOND = 3'b111
   } br_cond_e;

   typedef struct packed {
      logic z;
      logic v;
      logic n;
   } flags_t;

   // Which flags an opcode is allowed to load; arithmetic owns V and N,
   // logic/shift ops only report zero, lhb leaves everything alone.
   function automatic flags_t flag_enables(input alu_op_e op);
      flags_t en;
      en = '0;
      case (op)
         OP_ADD, OP_SUB: en = '1;
         OP_AND, OP_NOR, OP_SLL, OP_SRL, OP_SRA: en.z = 1'b1;
         default: en = '0;
      endcase
      return en;
   endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch condition evaluator: maps a 3-bit condition code and
// the Z/V/N flags to a single "condition holds" bit.
module br_cond_eval
   import wisc_pkg::*;
(
   input  logic [2:0] br_cond,
   input  logic       z,
   input  logic       v,
   input  logic       n,
   output logic       cond_true
);

   always_comb begin
      cond_true = 1'b0;
      case (br_cond_e'(br_cond))
         BR_NEQ:    cond_true = ~z;
         BR_EQ:     cond_true = z;
         BR_GT:     cond_true = ~z & ~n;
         BR_LT:     cond_true = n;
         BR_GTE:    cond_true = z | ~n;
         BR_LTE:    cond_true = n | z;
         BR_OVFL:   cond_true = v;
         BR_UNCOND: cond_true = 1'b1;
         default:   cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/flag_branch_unit.sv
// Z/V/N condition flag register with opcode-selective loading, plus branch
// resolution (taken decision and PC-relative target) for fetch.
module flag_branch_unit
   import wisc_pkg::*;
#(
   parameter int DW   = 16,
   parameter int OFFW = 9
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            alu_valid,
   input  logic [2:0]      alu_ops,
   input  logic            alu_ov,
   input  logic            alu_zr,
   input  logic            alu_n,
   input  logic            stall,
   input  logic            br_valid,
   input  logic [2:0]      br_cond,
   input  logic [OFFW-1:0] br_offset,
   input  logic [DW-1:0]   pc_inc,
   output logic            flag_z,
   output logic            flag_v,
   output logic            flag_n,
   output logic            br_taken,
   output logic [DW-1:0]   br_target
);

   flags_t flags_q;
   flags_t flags_d;
   flags_t flag_en;
   logic   update;
   logic   cond_true;
   logic [DW-1:0] offset_sx;

   assign update = alu_valid & ~stall;

   always_comb begin
      flag_en = flag_enables(alu_op_e'(alu_ops));
      flags_d = flags_q;
      if (update) begin
         if (flag_en.z) flags_d.z = alu_zr;
         if (flag_en.v) flags_d.v = alu_ov;
         if (flag_en.n) flags_d.n = alu_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign flag_z = flags_q.z;
   assign flag_v = flags_q.v;
   assign flag_n = flags_q.n;

   // Branches see the pre-edge flags, so a same-cycle ALU update is not visible.
   br_cond_eval u_br_cond_eval (
      .br_cond   (br_cond),
      .z         (flags_q.z),
      .v         (flags_q.v),
      .n         (flags_q.n),
      .cond_true (cond_true)
   );

   assign br_taken = br_valid & cond_true & rst_n;

   assign offset_sx = {{(DW-OFFW){br_offset[OFFW-1]}}, br_offset};
   assign br_target = pc_inc + offset_sx;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_flag_branch_unit;

   logic        clk;
   logic        rst_n;
   logic        alu_valid;
   logic [2:0]  alu_ops;
   logic        alu_ov;
   logic        alu_zr;
   logic        alu_n;
   logic        stall;
   logic        br_valid;
   logic [2:0]  br_cond;
   logic [8:0]  br_offset;
   logic [15:0] pc_inc;
   logic        flag_z;
   logic        flag_v;
   logic        flag_n;
   logic        br_taken;
   logic [15:0] br_target;

   int tests = 0;
   int fails = 0;

   logic m_z, m_v, m_n;

   flag_branch_unit #(.DW(16), .OFFW(9)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_valid (alu_valid),
      .alu_ops   (alu_ops),
      .alu_ov    (alu_ov),
      .alu_zr    (alu_zr),
      .alu_n     (alu_n),
      .stall     (stall),
      .br_valid  (br_valid),
      .br_cond   (br_cond),
      .br_offset (br_offset),
      .pc_inc    (pc_inc),
      .flag_z    (flag_z),
      .flag_v    (flag_v),
      .flag_n    (flag_n),
      .br_taken  (br_taken),
      .br_target (br_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: opcodes 0/1 are add/sub, 6 is lhb, the rest only report zero.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_z <= 1'b0; m_v <= 1'b0; m_n <= 1'b0;
      end else if (alu_valid === 1'b1 && stall === 1'b0) begin
         if (alu_ops == 3'd0 || alu_ops == 3'd1) begin
            m_z <= alu_zr; m_v <= alu_ov; m_n <= alu_n;
         end else if (alu_ops != 3'd6) begin
            m_z <= alu_zr;
         end
      end
   end

   function automatic logic model_cond(input logic [2:0] c, input logic z, input logic v, input logic n);
      // Signed compare semantics: "less" = N, "equal" = Z.
      bit eq, lt;
      eq = (z == 1'b1);
      lt = (n == 1'b1);
      case (c)
         3'd0: return !eq;
         3'd1: return eq;
         3'd2: return !eq && !lt;
         3'd3: return lt;
         3'd4: return eq || !lt;
         3'd5: return lt || eq;
         3'd6: return v == 1'b1;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [15:0] model_target(input logic [15:0] pc, input logic [8:0] off);
      int o;
      int t;
      o = (off >= 9'd256) ? int'(off) - 512 : int'(off);
      t = int'(pc) + o;
      t = t % 65536;
      if (t < 0) t += 65536;
      return t[15:0];
   endfunction

   always @(negedge clk) begin
      logic exp_taken;
      exp_taken = (rst_n === 1'b1) && (br_valid === 1'b1) && model_cond(br_cond, m_z, m_v, m_n);
      chk("cyc_flags", {13'd0, flag_z, flag_v, flag_n}, {13'd0, m_z, m_v, m_n});
      chk("cyc_taken", {15'd0, br_taken}, {15'd0, exp_taken});
      chk("cyc_target", br_target, model_target(pc_inc, br_offset));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic alu(input logic [2:0] op, input logic ov, input logic zr, input logic n, input logic stl);
      alu_valid = 1'b1; alu_ops = op; alu_ov = ov; alu_zr = zr; alu_n = n; stall = stl;
   endtask

   task automatic alu_idle();
      alu_valid = 1'b0; stall = 1'b0;
   endtask

   task automatic chk_flags(input string name, input logic [2:0] exp_zvn);
      chk(name, {13'd0, flag_z, flag_v, flag_n}, {13'd0, exp_zvn});
   endtask

   task automatic chk_br(input string name, input logic [2:0] c, input logic exp);
      br_valid = 1'b1; br_cond = c;
      #1;
      chk(name, {15'd0, br_taken}, {15'd0, exp});
   endtask

   initial begin
      rst_n = 1'b0; alu_valid = 1'b0; alu_ops = '0; alu_ov = 1'b0; alu_zr = 1'b0;
      alu_n = 1'b0; stall = 1'b0; br_valid = 1'b0; br_cond = '0; br_offset = '0; pc_inc = '0;

      tick(); tick();
      chk_flags("reset_flags", 3'b000);
      chk_br("reset_taken_uncond", 3'b111, 1'b0);
      rst_n = 1'b1;
      #1;
      chk_br("rst_eq_notaken", 3'b001, 1'b0);
      chk_br("rst_neq_taken", 3'b000, 1'b1);
      br_valid = 1'b0;
      #1;
      chk("brvalid0", {15'd0, br_taken}, 16'd0);

      // add ov=1 zr=0 n=1
      tick(); alu(3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(); alu_idle();
      chk_flags("add_flags", 3'b011);
      chk_br("ovfl_taken", 3'b110, 1'b1);
      chk_br("gt_notaken", 3'b010, 1'b0);
      chk_br("lt_taken", 3'b011, 1'b1);
      chk_br("gte_notaken", 3'b100, 1'b0);
      chk_br("lte_taken", 3'b101, 1'b1);
      br_valid = 1'b0;

      // sub zr=1 -> Z1 V0 N0
      tick(); alu(3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(); alu_idle();
      chk_flags("sub_flags", 3'b100);
      // nor with ov/n set: only Z follows
      tick(); alu(3'b011, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(); alu_idle();
      chk_flags("nor_flags", 3'b000);
      tick(); alu(3'b110, 1'b1, 1'b1, 1'b1, 1'b0);
      tick(); alu_idle();
      chk_flags("lhb_flags", 3'b000);

      // stalled add must not land
      tick(); alu(3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
      tick(); alu_idle();
      chk_flags("stall_hold", 3'b000);
      tick(); alu(3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(); alu_idle();
      chk_flags("unstall_load", 3'b100);

      // and zr=0 clears Z, then same-cycle add zr=1 with branch eq
      tick(); alu(3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); alu(3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
      chk_br("samecyc_eq_old", 3'b001, 1'b0);
      tick(); alu_idle();
      chk_br("nextcyc_eq_new", 3'b001, 1'b1);
      br_valid = 1'b0;

      // target arithmetic
      pc_inc = 16'h0010; br_offset = 9'h1FF; #1;
      chk("tgt_minus1", br_target, 16'h000F);
      pc_inc = 16'hFFFF; br_offset = 9'h002; #1;
      chk("tgt_wrap", br_target, 16'h0001);
      pc_inc = 16'h0050; br_offset = 9'h100; #1;
      chk("tgt_min", br_target, 16'hFF50);
      pc_inc = 16'h1234; br_offset = 9'h0FF; #1;
      chk("tgt_max", br_target, 16'h1333);

      // mid-cycle asynchronous reset
      tick(); alu(3'b000, 1'b1, 1'b1, 1'b1, 1'b0);
      tick(); alu_idle();
      chk_flags("preasync_flags", 3'b111);
      #2; rst_n = 1'b0; #1;
      chk_flags("async_clear", 3'b000);
      chk_br("async_taken0", 3'b111, 1'b0);
      br_valid = 1'b0;
      tick(); #2; rst_n = 1'b1;
      alu(3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(); alu_idle();
      chk_flags("first_after_reset", 3'b010);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
